// File: rtl/fft_pkg.sv
// Shared FFT-path constants, state encoding and helpers used by the interface
// stage, the peak detector and the magnitude approximator.
package fft_pkg;

    localparam int unsigned Nb        = 18;
    localparam int unsigned log_depth = 10;
    localparam int unsigned N         = 32'(1) << log_depth;
    localparam int unsigned MAG_W     = Nb + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        REPORT  = 2'd3
    } fft_state_e;

    // |x| as unsigned Nb bits; the most negative input maps to 2^(Nb-1) exactly.
    function automatic logic [Nb-1:0] abs_u(input logic signed [Nb-1:0] x);
        return x[Nb-1] ? Nb'(-x) : Nb'(x);
    endfunction

endpackage

// File: rtl/fft_mag_approx.sv
// Two-stage registered magnitude estimate: |re|,|im| then max + min/2.
// A tag travels with each sample so callers can track bin indices.
module fft_mag_approx
    import fft_pkg::*;
#(
    parameter int unsigned TAG_W = log_depth
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_i,
    input  logic                    flush_i,
    input  logic signed [Nb-1:0]    re_i,
    input  logic signed [Nb-1:0]    im_i,
    input  logic [TAG_W-1:0]        tag_i,
    output logic                    valid_o,
    output logic [MAG_W-1:0]        mag_o,
    output logic [TAG_W-1:0]        tag_o
);

    logic              s1_valid_q;
    logic [Nb-1:0]     s1_a_q;
    logic [Nb-1:0]     s1_b_q;
    logic [TAG_W-1:0]  s1_tag_q;
    logic              s2_valid_q;
    logic [MAG_W-1:0]  s2_mag_q;
    logic [TAG_W-1:0]  s2_tag_q;

    logic [Nb-1:0]     max_c;
    logic [Nb-1:0]     min_c;
    logic [MAG_W-1:0]  mag_c;

    always_comb begin
        max_c = (s1_a_q >= s1_b_q) ? s1_a_q : s1_b_q;
        min_c = (s1_a_q >= s1_b_q) ? s1_b_q : s1_a_q;
        mag_c = MAG_W'(max_c) + MAG_W'(min_c >> 1);
    end

    // flush_i kills whatever is in S1 so it never reaches S2.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_mag_q   <= '0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= valid_i;
            s1_a_q     <= abs_u(re_i);
            s1_b_q     <= abs_u(im_i);
            s1_tag_q   <= tag_i;
            s2_valid_q <= s1_valid_q & ~flush_i;
            s2_mag_q   <= mag_c;
            s2_tag_q   <= s1_tag_q;
        end
    end

    assign valid_o = s2_valid_q;
    assign mag_o   = s2_mag_q;
    assign tag_o   = s2_tag_q;

endmodule

// File: rtl/fft_peak_detector.sv
// Per-frame search for the strongest FFT bin inside [MIN_BIN, MAX_BIN],
// reported with its approximate magnitude and a threshold flag.
module fft_peak_detector
    import fft_pkg::*;
#(
    parameter int unsigned MIN_BIN = 1,
    parameter int unsigned MAX_BIN = 511
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic                    in_first,
    input  logic signed [Nb-1:0]    in_real,
    input  logic signed [Nb-1:0]    in_imag,
    input  logic [MAG_W-1:0]        threshold,
    output logic [log_depth-1:0]    peak_bin,
    output logic [MAG_W-1:0]        peak_mag,
    output logic                    peak_found,
    output logic                    result_valid,
    output logic                    frame_error
);

    fft_state_e            state_q;
    logic [log_depth-1:0]  cnt_q;
    logic                  drain_q;
    logic [MAG_W-1:0]      best_mag_q;
    logic [log_depth-1:0]  best_bin_q;
    logic [log_depth-1:0]  peak_bin_q;
    logic [MAG_W-1:0]      peak_mag_q;
    logic                  peak_found_q;
    logic                  result_valid_q;
    logic                  frame_error_q;

    logic                  accept_c;
    logic                  start_c;
    logic [log_depth-1:0]  bin_idx_c;
    logic                  in_win_c;
    logic                  peak_found_d;

    logic                  s2_valid;
    logic [MAG_W-1:0]      s2_mag;
    logic [log_depth-1:0]  s2_bin;

    // Sample acceptance: a first-flagged sample (re)starts a frame at bin 0.
    always_comb begin
        accept_c  = 1'b0;
        start_c   = 1'b0;
        bin_idx_c = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_first) begin
                    accept_c  = 1'b1;
                    start_c   = 1'b1;
                    bin_idx_c = '0;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    accept_c = 1'b1;
                    if (in_first) begin
                        start_c   = 1'b1;
                        bin_idx_c = '0;
                    end
                end
            end
            default: ;
        endcase
        in_win_c     = (32'(s2_bin) >= MIN_BIN) && (32'(s2_bin) <= MAX_BIN);
        peak_found_d = (best_mag_q >= threshold);
    end

    fft_mag_approx #(
        .TAG_W   (log_depth)
    ) u_mag (
        .clk     (clk),
        .reset   (reset),
        .valid_i (accept_c),
        .flush_i (start_c),
        .re_i    (in_real),
        .im_i    (in_imag),
        .tag_i   (bin_idx_c),
        .valid_o (s2_valid),
        .mag_o   (s2_mag),
        .tag_o   (s2_bin)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            drain_q        <= 1'b0;
            best_mag_q     <= '0;
            best_bin_q     <= '0;
            peak_bin_q     <= '0;
            peak_mag_q     <= '0;
            peak_found_q   <= 1'b0;
            result_valid_q <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            frame_error_q  <= 1'b0;

            // Strict '>' keeps the lowest index on ties; a frame start wins over stale data.
            if (start_c) begin
                best_mag_q <= '0;
                best_bin_q <= log_depth'(MIN_BIN);
            end else if (s2_valid && in_win_c && (s2_mag > best_mag_q)) begin
                best_mag_q <= s2_mag;
                best_bin_q <= s2_bin;
            end

            unique case (state_q)
                IDLE: begin
                    if (start_c) begin
                        cnt_q   <= log_depth'(1);
                        state_q <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (in_valid) begin
                        if (in_first) begin
                            frame_error_q <= 1'b1;
                            cnt_q         <= log_depth'(1);
                        end else if (cnt_q == log_depth'(N - 1)) begin
                            cnt_q   <= '0;
                            drain_q <= 1'b0;
                            state_q <= DRAIN;
                        end else begin
                            cnt_q <= cnt_q + log_depth'(1);
                        end
                    end
                end
                DRAIN: begin
                    frame_error_q <= in_valid & in_first;
                    drain_q       <= 1'b1;
                    if (drain_q) begin
                        state_q <= REPORT;
                    end
                end
                REPORT: begin
                    frame_error_q  <= in_valid & in_first;
                    peak_found_q   <= peak_found_d;
                    peak_bin_q     <= peak_found_d ? best_bin_q : '0;
                    peak_mag_q     <= best_mag_q;
                    result_valid_q <= 1'b1;
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign peak_bin     = peak_bin_q;
    assign peak_mag     = peak_mag_q;
    assign peak_found   = peak_found_q;
    assign result_valid = result_valid_q;
    assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_fft_peak_detector.sv
// Directed-vector bench for fft_peak_detector: sparse frames with
// hand-computed peaks, abort/drop handling, reset and gapped input.
module tb_fft_peak_detector;
    import fft_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  in_valid;
    logic                  in_first;
    logic signed [Nb-1:0]  in_real;
    logic signed [Nb-1:0]  in_imag;
    logic [MAG_W-1:0]      threshold;
    logic [log_depth-1:0]  peak_bin;
    logic [MAG_W-1:0]      peak_mag;
    logic                  peak_found;
    logic                  result_valid;
    logic                  frame_error;

    int re_a [N];
    int im_a [N];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rv_cnt  = 0;
    int fe_cnt  = 0;
    int rv_cyc  = 0;
    int acc_cyc = 0;
    int rv0;
    int fe0;

    fft_peak_detector #(
        .MIN_BIN      (1),
        .MAX_BIN      (511)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_first     (in_first),
        .in_real      (in_real),
        .in_imag      (in_imag),
        .threshold    (threshold),
        .peak_bin     (peak_bin),
        .peak_mag     (peak_mag),
        .peak_found   (peak_found),
        .result_valid (result_valid),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            rv_cnt <= rv_cnt + 1;
            rv_cyc <= cyc;
        end
        if (frame_error === 1'b1) fe_cnt <= fe_cnt + 1;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_bins();
        for (int i = 0; i < int'(N); i++) begin
            re_a[i] = 0;
            im_a[i] = 0;
        end
    endtask

    // Drives bins 0..n-1 from the arrays; the last one is accepted on the following edge.
    task automatic drive_bins(input int n, input bit gaps);
        int g;
        for (int i = 0; i < n; i++) begin
            g = gaps ? int'($urandom_range(0, 2)) : 0;
            repeat (g) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                in_first = 1'b0;
            end
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_first = (i == 0);
            in_real  = Nb'(re_a[i]);
            in_imag  = Nb'(im_a[i]);
            if (i == int'(N) - 1) acc_cyc = cyc + 1;
        end
    endtask

    task automatic stop_and_wait();
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_first = 1'b0;
        in_real = '0; in_imag = '0; threshold = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_peak_bin", peak_bin, 0);
        check("rst_peak_mag", peak_mag, 0);
        check("rst_peak_found", peak_found, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_frame_error", frame_error, 0);
        reset = 1'b0;

        // Single peak at bin 37: 1000 + 400/2.
        clear_bins(); re_a[37] = 1000; im_a[37] = -400; threshold = 100;
        rv0 = rv_cnt;
        drive_bins(N, 1'b0); stop_and_wait();
        check("t1_rv", rv_cnt - rv0, 1);
        check("t1_bin", peak_bin, 37);
        check("t1_mag", peak_mag, 1200);
        check("t1_found", peak_found, 1);

        // Tie between bins 20 and 90, plus a first-flagged sample landing in DRAIN.
        clear_bins(); re_a[20] = 500; im_a[20] = 500; re_a[90] = 500; im_a[90] = 500;
        rv0 = rv_cnt; fe0 = fe_cnt;
        drive_bins(N, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b1; in_first = 1'b1; in_real = Nb'(77777); in_imag = '0;
        stop_and_wait();
        check("t2_rv", rv_cnt - rv0, 1);
        check("t2_fe", fe_cnt - fe0, 1);
        check("t2_bin", peak_bin, 20);
        check("t2_mag", peak_mag, 750);
        check("t2_found", peak_found, 1);

        // DC and upper half excluded from the search.
        clear_bins(); re_a[0] = 100000; re_a[700] = 120000; re_a[5] = 10; threshold = 5;
        drive_bins(N, 1'b0); stop_and_wait();
        check("t3_bin", peak_bin, 5);
        check("t3_mag", peak_mag, 10);
        check("t3_found", peak_found, 1);

        // Full-scale negative corner below threshold forces bin 0.
        clear_bins(); re_a[200] = -131072; im_a[200] = -131072; threshold = 200000;
        drive_bins(N, 1'b0); stop_and_wait();
        check("t4_mag", peak_mag, 196608);
        check("t4_found", peak_found, 0);
        check("t4_bin", peak_bin, 0);

        // Abort after 300 bins, then a full frame with its peak at bin 12.
        clear_bins(); re_a[100] = 50000; threshold = 100;
        rv0 = rv_cnt; fe0 = fe_cnt;
        drive_bins(300, 1'b0);
        clear_bins(); re_a[12] = 700;
        drive_bins(N, 1'b0); stop_and_wait();
        check("t5_fe", fe_cnt - fe0, 1);
        check("t5_rv", rv_cnt - rv0, 1);
        check("t5_bin", peak_bin, 12);
        check("t5_mag", peak_mag, 700);
        check("t5_latency", rv_cyc - acc_cyc, 3);

        // Reset in the middle of a frame.
        clear_bins(); re_a[50] = 9999;
        rv0 = rv_cnt;
        drive_bins(500, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_first = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        check("t6_bin", peak_bin, 0);
        check("t6_mag", peak_mag, 0);
        check("t6_found", peak_found, 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("t6_rv", rv_cnt - rv0, 0);

        // Randomly gapped frame.
        clear_bins(); re_a[400] = -3000; im_a[400] = 2000; re_a[600] = 100000; re_a[0] = 50000;
        threshold = 100;
        rv0 = rv_cnt;
        drive_bins(N, 1'b1); stop_and_wait();
        check("t7_rv", rv_cnt - rv0, 1);
        check("t7_bin", peak_bin, 400);
        check("t7_mag", peak_mag, 4000);
        check("t7_found", peak_found, 1);
        check("t7_latency", rv_cyc - acc_cyc, 3);

        check("total_results", rv_cnt, 6);
        check("total_frame_errors", fe_cnt, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
